// File: rtl/posit_decode_pipe_pkg.sv
// rtl/posit_decode_pipe_pkg.sv - posit format constants and decoded-tuple type
package posit_pkg;

  localparam int POSIT_N  = 32;
  localparam int POSIT_ES = 2;
  localparam int POSIT_RS = $clog2(POSIT_N);

  localparam logic [POSIT_N-1:0] POSIT_ZERO = '0;
  localparam logic [POSIT_N-1:0] POSIT_NAR  = {1'b1, {(POSIT_N-1){1'b0}}};

  typedef struct packed {
    logic                           sign;
    logic signed [POSIT_RS:0]       r;
    logic [POSIT_ES-1:0]            e;
    logic signed [POSIT_ES+POSIT_RS:0] le;
    logic [POSIT_N-1:0]             mant;
    logic                           zero;
    logic                           inf;
  } posit_dec_t;

endpackage

// File: rtl/posit_decode_pipe_if.sv
// rtl/posit_decode_pipe_if.sv - input word and decoded-field handshake bundle
interface posit_decode_if
  import posit_pkg::*;
#(
  parameter int N  = POSIT_N,
  parameter int ES = POSIT_ES,
  parameter int RS = $clog2(N)
);

  logic                 in_valid;
  logic                 in_ready;
  logic [N-1:0]         in_posit;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_sign;
  logic signed [RS:0]   out_R;
  logic [ES-1:0]        out_E;
  logic signed [ES+RS:0] out_LE;
  logic [N-1:0]         out_mant;
  logic                 out_zero;
  logic                 out_inf;

  modport master (
    output in_valid, in_posit, out_ready,
    input  in_ready, out_valid, out_sign, out_R, out_E, out_LE,
           out_mant, out_zero, out_inf
  );

  modport slave (
    input  in_valid, in_posit, out_ready,
    output in_ready, out_valid, out_sign, out_R, out_E, out_LE,
           out_mant, out_zero, out_inf
  );

endinterface

// File: rtl/posit_decode_pipe_lzd.sv
// rtl/posit_decode_pipe_lzd.sv - counts the leading run of rc-valued bits
module posit_lzd
  import posit_pkg::*;
#(
  parameter int N  = POSIT_N,
  parameter int RS = $clog2(N)
) (
  input  logic [N-2:0]  bits,
  input  logic          rc,
  output logic [RS-1:0] k
);

  logic run;

  always_comb begin
    k   = '0;
    run = 1'b1;
    for (int i = N - 2; i >= 0; i--) begin
      if (run && (bits[i] == rc)) begin
        k = k + RS'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/posit_decode_pipe.sv
// rtl/posit_decode_pipe.sv - two-stage posit unpacker: S1 sign/abs/flags, S2 regime/exp/mantissa
module posit_decode_pipe
  import posit_pkg::*;
#(
  parameter int N  = POSIT_N,
  parameter int ES = POSIT_ES,
  parameter int RS = $clog2(N)
) (
  input logic            clk,
  input logic            rst,
  posit_decode_if.slave  bus
);

  logic                s1_adv, s2_adv, in_accept;

  logic                s1_valid_q, s1_valid_d;
  logic                s1_sign_q, s1_sign_d;
  logic [N-2:0]        s1_abs_q, s1_abs_d;
  logic                s1_zero_q, s1_zero_d;
  logic                s1_inf_q, s1_inf_d;

  logic                s2_valid_q, s2_valid_d;
  logic                s2_sign_q, s2_sign_d;
  logic [RS:0]         s2_r_q, s2_r_d;
  logic [ES-1:0]       s2_e_q, s2_e_d;
  logic [ES+RS:0]      s2_le_q, s2_le_d;
  logic [N-1:0]        s2_mant_q, s2_mant_d;
  logic                s2_zero_q, s2_zero_d;
  logic                s2_inf_q, s2_inf_d;

  logic                rc;
  logic [RS-1:0]       k;
  logic [RS:0]         kx, shamt, dec_r;
  logic [N-2:0]        shifted;
  logic [ES-1:0]       dec_e;
  logic [N-2-ES:0]     dec_frac;

  assign s2_adv    = !s2_valid_q || bus.out_ready;
  assign s1_adv    = !s1_valid_q || s2_adv;
  assign in_accept = bus.in_valid && s1_adv;

  // Low N-1 bits of the two's complement are all S2 needs; the top bit of |p| is never set except for NaR.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_abs_d   = s1_abs_q;
    s1_zero_d  = s1_zero_q;
    s1_inf_d   = s1_inf_q;
    if (s1_adv) begin
      s1_valid_d = bus.in_valid;
    end
    if (in_accept) begin
      s1_sign_d = bus.in_posit[N-1];
      s1_abs_d  = (bus.in_posit[N-2:0] ^ {(N-1){bus.in_posit[N-1]}})
                + {{(N-2){1'b0}}, bus.in_posit[N-1]};
      s1_zero_d = (bus.in_posit == '0);
      s1_inf_d  = (bus.in_posit == {1'b1, {(N-1){1'b0}}});
    end
  end

  assign rc = s1_abs_q[N-2];

  posit_lzd #(.N(N), .RS(RS)) u_lzd (
    .bits (s1_abs_q),
    .rc   (rc),
    .k    (k)
  );

  // Shift past the run and its terminator; a shift of N clears everything when no terminator exists.
  always_comb begin
    kx       = {1'b0, k};
    shamt    = kx + (RS+1)'(1);
    shifted  = s1_abs_q << shamt;
    dec_r    = rc ? (kx - (RS+1)'(1)) : ((~kx) + (RS+1)'(1));
    dec_e    = shifted[N-2 -: ES];
    dec_frac = shifted[N-2-ES:0];
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_r_d     = s2_r_q;
    s2_e_d     = s2_e_q;
    s2_le_d    = s2_le_q;
    s2_mant_d  = s2_mant_q;
    s2_zero_d  = s2_zero_q;
    s2_inf_d   = s2_inf_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
    end
    if (s2_adv && s1_valid_q) begin
      s2_sign_d = s1_sign_q;
      s2_zero_d = s1_zero_q;
      s2_inf_d  = s1_inf_q;
      if (s1_zero_q || s1_inf_q) begin
        s2_r_d    = '0;
        s2_e_d    = '0;
        s2_le_d   = '0;
        s2_mant_d = '0;
      end else begin
        s2_r_d    = dec_r;
        s2_e_d    = dec_e;
        s2_le_d   = {dec_r, dec_e};
        s2_mant_d = {1'b1, dec_frac, {ES{1'b0}}};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_abs_q   <= '0;
      s1_zero_q  <= 1'b0;
      s1_inf_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_r_q     <= '0;
      s2_e_q     <= '0;
      s2_le_q    <= '0;
      s2_mant_q  <= '0;
      s2_zero_q  <= 1'b0;
      s2_inf_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_abs_q   <= s1_abs_d;
      s1_zero_q  <= s1_zero_d;
      s1_inf_q   <= s1_inf_d;
      s2_valid_q <= s2_valid_d;
      s2_sign_q  <= s2_sign_d;
      s2_r_q     <= s2_r_d;
      s2_e_q     <= s2_e_d;
      s2_le_q    <= s2_le_d;
      s2_mant_q  <= s2_mant_d;
      s2_zero_q  <= s2_zero_d;
      s2_inf_q   <= s2_inf_d;
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_sign  = s2_sign_q;
  assign bus.out_R     = s2_r_q;
  assign bus.out_E     = s2_e_q;
  assign bus.out_LE    = s2_le_q;
  assign bus.out_mant  = s2_mant_q;
  assign bus.out_zero  = s2_zero_q;
  assign bus.out_inf   = s2_inf_q;

endmodule

// File: tb/tb_posit_decode_pipe.sv
// tb/tb_posit_decode_pipe.sv - randomized and directed bench for posit_decode_pipe
module tb_posit_decode_pipe;
  import posit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  posit_dec_t    q[$];
  logic [31:0]   specials[6];
  logic [31:0]   dir_p[8];
  posit_dec_t    dir_e[8];
  logic [63:0]   got;

  always #5 clk = ~clk;

  posit_decode_if #(.N(32), .ES(2)) bus ();

  posit_decode_pipe #(.N(32), .ES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign got = {13'b0, bus.out_sign, bus.out_R, bus.out_E, bus.out_LE,
                bus.out_mant, bus.out_zero, bus.out_inf};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack(input posit_dec_t d);
    return {13'b0, d};
  endfunction

  function automatic posit_dec_t mk(input logic s, input int r, input logic [1:0] e,
                                    input int le, input logic [31:0] m,
                                    input logic z, input logic i);
    posit_dec_t d;
    d.sign = s;
    d.r    = 6'(r);
    d.e    = e;
    d.le   = 8'(le);
    d.mant = m;
    d.zero = z;
    d.inf  = i;
    return d;
  endfunction

  // Reference decode: walk the regime bit by bit on |p|, then left-align the leftover tail.
  function automatic posit_dec_t model(input logic [31:0] p);
    posit_dec_t  d;
    logic [63:0] a, rest, tail;
    logic        rc;
    int          k, rem, rint;
    d = '0;
    d.sign = p[31];
    if (p == 32'h0) begin
      d.zero = 1'b1;
      return d;
    end
    if (p == 32'h8000_0000) begin
      d.inf = 1'b1;
      return d;
    end
    a    = p[31] ? (64'h1_0000_0000 - {32'b0, p}) : {32'b0, p};
    rest = a & 64'h7FFF_FFFF;
    rc   = rest[30];
    k    = 0;
    while (k < 31 && rest[30-k] == rc) k++;
    rem = 30 - k;
    if (rem < 0) rem = 0;
    tail = rest & ((64'd1 << rem) - 64'd1);
    tail = tail << (31 - rem);
    rint = rc ? k - 1 : -k;
    d.r    = 6'(rint);
    d.e    = tail[30:29];
    d.le   = 8'(rint * 4 + int'(d.e));
    d.mant = {1'b1, tail[28:0], 2'b00};
    return d;
  endfunction

  function automatic logic [31:0] rand_posit();
    case ($urandom_range(0, 7))
      0:       return specials[$urandom_range(0, 5)];
      1:       return $urandom >> $urandom_range(0, 31);
      2:       return ~($urandom >> $urandom_range(0, 31));
      default: return $urandom;
    endcase
  endfunction

  task automatic send_directed(input logic [31:0] p, input posit_dec_t exp, input string tag);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_posit  = p;
    bus.out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk({tag, "_valid_t"}, 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk({tag, "_valid_t1"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_fields"}, got, pack(exp));
    @(posedge clk);
    #1;
    chk({tag, "_drained"}, 64'(bus.out_valid), 64'd0);
  endtask

  task automatic run_stream(input int nwords, input bit random_mode);
    int sent = 0;
    int cyc  = 0;
    while ((sent < nwords || q.size() > 0) && cyc < 4000) begin
      @(negedge clk);
      bus.in_valid  = (sent < nwords) && (random_mode ? ($urandom_range(0, 3) != 0) : 1'b1);
      bus.in_posit  = rand_posit();
      bus.out_ready = random_mode ? 1'($urandom_range(0, 1)) : (cyc % 3 == 0);
      #1;
      chk("in_ready", 64'(bus.in_ready), 64'(!(q.size() == 2 && !bus.out_ready)));
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk("extra_out", 64'(bus.out_valid), 64'd0);
        end else begin
          chk("stream_data", got, pack(q[0]));
          if (bus.out_ready) void'(q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.in_posit));
        sent++;
      end
      cyc++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("drain", 64'(q.size()), 64'd0);
    q.delete();
  endtask

  initial begin
    specials = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0001,
                 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001};
    dir_p[0] = 32'h4000_0000; dir_e[0] = mk(0,   0, 2'd0,    0, 32'h8000_0000, 0, 0);
    dir_p[1] = 32'h4800_0000; dir_e[1] = mk(0,   0, 2'd1,    1, 32'h8000_0000, 0, 0);
    dir_p[2] = 32'hC000_0000; dir_e[2] = mk(1,   0, 2'd0,    0, 32'h8000_0000, 0, 0);
    dir_p[3] = 32'h0000_0001; dir_e[3] = mk(0, -30, 2'd0, -120, 32'h8000_0000, 0, 0);
    dir_p[4] = 32'h7FFF_FFFF; dir_e[4] = mk(0,  30, 2'd0,  120, 32'h8000_0000, 0, 0);
    dir_p[5] = 32'h0000_0000; dir_e[5] = mk(0,   0, 2'd0,    0, 32'h0000_0000, 1, 0);
    dir_p[6] = 32'h8000_0000; dir_e[6] = mk(1,   0, 2'd0,    0, 32'h0000_0000, 0, 1);
    dir_p[7] = 32'h4C00_0000; dir_e[7] = mk(0,   0, 2'd1,    1, 32'hC000_0000, 0, 0);

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_posit  = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_fields", got, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);

    for (int i = 0; i < 8; i++) begin
      send_directed(dir_p[i], dir_e[i], $sformatf("dir%0d", i));
    end

    run_stream(8, 1'b0);

    // Async reset with two words in flight and the consumer stalled.
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_posit  = 32'h4800_0000;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_posit  = 32'h4000_0000;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("inflight_valid", 64'(bus.out_valid), 64'd1);
    chk("inflight_full", 64'(bus.in_ready), 64'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("async_rst_fields", got, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    send_directed(32'hC000_0000, mk(1, 0, 2'd0, 0, 32'h8000_0000, 0, 0), "after_rst");

    run_stream(300, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
